// File: rtl/bit_stream_packer_pkg.sv
// Shared types for the serial bit packer: word/length widths, FIFO entry and FIFO state.
// Purely declarative; no logic.
package bit_stream_packer_pkg;

    localparam int PKG_W     = 8;
    localparam int PKG_CNT_W = 8;
    localparam int LEN_W     = $clog2(PKG_W + 1);

    typedef logic [PKG_W-1:0] word_t;
    typedef logic [LEN_W-1:0] len_t;

    typedef struct packed {
        word_t word;
        len_t  len;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } fifo_state_e;

endpackage

// File: rtl/bit_stream_packer_fifo2.sv
// Two-entry FIFO of packed words with a registered head.
// Latency: a push into an empty FIFO is visible on head_dat/head_vld the next cycle.
// Backpressure: a push into FULL without a pop is ignored; the caller accounts for the drop.
module bit_stream_packer_fifo2
    import bit_stream_packer_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   push_vld,
    input  entry_t push_dat,
    input  logic   pop,
    output entry_t head_dat,
    output logic   head_vld,
    output logic   full,
    output logic   empty
);

    fifo_state_e state;
    entry_t      tail;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= EMPTY;
            head_vld <= 1'b0;
            head_dat <= '0;
            tail     <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push_vld) begin
                        head_dat <= push_dat;
                        head_vld <= 1'b1;
                        state    <= ONE;
                    end
                end
                ONE: begin
                    if (push_vld && pop) begin
                        head_dat <= push_dat;
                    end else if (push_vld) begin
                        tail  <= push_dat;
                        state <= FULL;
                    end else if (pop) begin
                        head_vld <= 1'b0;
                        state    <= EMPTY;
                    end
                end
                FULL: begin
                    // The pop frees the tail slot, so a same-cycle push still lands.
                    if (pop) begin
                        head_dat <= tail;
                        if (push_vld) begin
                            tail <= push_dat;
                        end else begin
                            state <= ONE;
                        end
                    end
                end
                default: begin
                    head_vld <= 1'b0;
                    state    <= EMPTY;
                end
            endcase
        end
    end

    assign full  = (state == FULL);
    assign empty = (state == EMPTY);

endmodule

// File: rtl/bit_stream_packer.sv
// Packs a 1-bit-per-cycle stream LSB-first into W-bit words and queues them for a valid/ready consumer.
// Latency: a word appears on out_word 1 cycle after its last bit (or flush) when the queue is empty.
// Backpressure: the upstream cannot stall; a push into a full queue drops the word and flags overflow.
module bit_stream_packer
    import bit_stream_packer_pkg::*;
#(
    parameter int W     = PKG_W,
    parameter int CNT_W = PKG_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_bit,
    input  logic                   in_en,
    input  logic                   flush,
    input  logic                   clear_ovf,
    output logic [W-1:0]           out_word,
    output logic [$clog2(W+1)-1:0] out_len,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   overflow,
    output logic [CNT_W-1:0]       drop_cnt
);

    // Word and length types come from the package, so W must match it.
    if (W != PKG_W || W < 2 || W > 32) begin : g_bad_w
        $error("bit_stream_packer: W must equal PKG_W and lie in 2..32");
    end

    word_t  acc;
    len_t   cnt;
    word_t  acc_s;
    len_t   n;
    logic   completing;
    logic   push;
    logic   pop;
    logic   drop;
    logic   fifo_full;
    logic   fifo_empty;
    entry_t push_dat;
    entry_t head_dat;

    always_comb begin
        acc_s      = acc;
        if (in_en) begin
            acc_s = acc | (word_t'(in_bit) << cnt);
        end
        n          = cnt + len_t'(in_en);
        completing = in_en && (cnt == len_t'(W - 1));
        push       = completing || (flush && (n != '0));
        push_dat.word = acc_s;
        push_dat.len  = completing ? len_t'(W) : n;
    end

    assign pop  = out_ready && !fifo_empty;
    assign drop = push && fifo_full && !pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (push) begin
            acc <= '0;
            cnt <= '0;
        end else if (in_en) begin
            acc <= acc_s;
            cnt <= n;
        end
    end

    // A drop in the same cycle as a clear wins: the count restarts at one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clear_ovf) begin
            overflow <= drop;
            drop_cnt <= drop ? CNT_W'(1) : '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

    bit_stream_packer_fifo2 u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .head_vld (out_valid),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign out_word = head_dat.word;
    assign out_len  = head_dat.len;

endmodule

// File: tb/tb_bit_stream_packer.sv
// Directed bench for bit_stream_packer (W=8): expected words are queued at stimulus time
// and a negedge monitor compares every accepted output against the queue head.
module tb_bit_stream_packer;

    localparam int W     = 8;
    localparam int CNT_W = 8;
    localparam int LW    = $clog2(W + 1);

    typedef struct {
        logic [W-1:0]  w;
        logic [LW-1:0] l;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_bit = 1'b0;
    logic             in_en = 1'b0;
    logic             flush = 1'b0;
    logic             clear_ovf = 1'b0;
    logic [W-1:0]     out_word;
    logic [LW-1:0]    out_len;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             overflow;
    logic [CNT_W-1:0] drop_cnt;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    bit_stream_packer #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_bit    (in_bit),
        .in_en     (in_en),
        .flush     (flush),
        .clear_ovf (clear_ovf),
        .out_word  (out_word),
        .out_len   (out_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic expect_word(input logic [W-1:0] w, input logic [LW-1:0] l);
        exp_t e;
        e.w = w;
        e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            in_en  = 1'b1;
            in_bit = v[i];
            cyc();
        end
        in_en  = 1'b0;
        in_bit = 1'b0;
    endtask

    // Scoreboard monitor: every accepted word must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got word %0h len %0d, expected none", out_word, out_len);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_word", 32'(out_word), 32'(e.w));
                    chk("out_len", 32'(out_len), 32'(e.l));
                end
            end
        end
    end

    initial begin
        // Reset state
        #12;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_word", 32'(out_word), 0);
        chk("rst_len", 32'(out_len), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        rst = 1'b1;
        cyc();

        // Full word, bits 1,0,1,1,0,0,0,1 -> 8Dh, one cycle valid
        out_ready = 1'b1;
        expect_word(8'h8D, 4'd8);
        send_bits(32'h8D, 8);
        chk("t1_valid_next", 32'(out_valid), 1);
        cyc();
        chk("t1_valid_once", 32'(out_valid), 0);

        // Partial flush of bits 1,1,0 -> 03h len 3; empty flush produces nothing
        expect_word(8'h03, 4'd3);
        send_bits(32'h3, 3);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        idle(3);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        idle(3);
        chk("t2_queue_empty", 32'(exp_q.size()), 0);

        // Overflow: 11h, 22h kept, 33h dropped
        out_ready = 1'b0;
        expect_word(8'h11, 4'd8);
        expect_word(8'h22, 4'd8);
        send_bits(32'h11, 8);
        send_bits(32'h22, 8);
        send_bits(32'h33, 8);
        chk("t3_ovf", 32'(overflow), 1);
        chk("t3_drop", 32'(drop_cnt), 1);
        chk("t3_valid_held", 32'(out_valid), 1);
        chk("t3_head_stable", 32'(out_word), 32'h11);
        out_ready = 1'b1;
        idle(4);
        chk("t3_drained", 32'(exp_q.size()), 0);

        // FULL with a pop coinciding with the last bit of 44h: no drop
        out_ready = 1'b0;
        expect_word(8'h11, 4'd8);
        expect_word(8'h22, 4'd8);
        expect_word(8'h44, 4'd8);
        send_bits(32'h11, 8);
        send_bits(32'h22, 8);
        send_bits(32'h44, 7);
        in_en     = 1'b1;
        in_bit    = 1'b0;
        out_ready = 1'b1;
        cyc();
        in_en = 1'b0;
        idle(4);
        chk("t4_drop_unchanged", 32'(drop_cnt), 1);
        chk("t4_drained", 32'(exp_q.size()), 0);

        // Flush coinciding with completion: exactly one full word
        expect_word(8'hA5, 4'd8);
        send_bits(32'h25, 7);
        in_en  = 1'b1;
        in_bit = 1'b1;
        flush  = 1'b1;
        cyc();
        in_en = 1'b0;
        flush = 1'b0;
        idle(3);
        chk("t5_single_word", 32'(exp_q.size()), 0);
        clear_ovf = 1'b1;
        cyc();
        clear_ovf = 1'b0;
        chk("t5_clr_ovf", 32'(overflow), 0);
        chk("t5_clr_drop", 32'(drop_cnt), 0);

        // Clear coinciding with a drop, then saturation of the drop counter
        out_ready = 1'b0;
        send_bits(32'hC1, 8);
        send_bits(32'hC2, 8);
        send_bits(32'h03, 7);
        in_en     = 1'b1;
        in_bit    = 1'b1;
        clear_ovf = 1'b1;
        cyc();
        in_en     = 1'b0;
        clear_ovf = 1'b0;
        chk("clr_drop_ovf", 32'(overflow), 1);
        chk("clr_drop_cnt", 32'(drop_cnt), 1);
        for (int i = 0; i < 260; i++) send_bits(32'h5, 8);
        chk("sat_drop_cnt", 32'(drop_cnt), 32'hFF);
        chk("sat_head_kept", 32'(out_word), 32'hC1);

        // Async reset mid-word with one buffered word
        rst = 1'b0;
        #3;
        rst = 1'b1;
        exp_q.delete();
        cyc();
        send_bits(32'h77, 8);
        send_bits(32'h1, 3);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_async_valid", 32'(out_valid), 0);
        chk("t6_async_word", 32'(out_word), 0);
        chk("t6_async_ovf", 32'(overflow), 0);
        chk("t6_async_drop", 32'(drop_cnt), 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        cyc();
        out_ready = 1'b1;
        expect_word(8'h5A, 4'd8);
        send_bits(32'h5A, 8);
        chk("t6_clean_valid", 32'(out_valid), 1);
        idle(3);
        chk("t6_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
